// File: rtl/aes_pkg.sv
// Shared types and round-count constants for the AES round sequencer.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Reserved encoding 3 falls back to AES-128.
    function automatic int nr_decode(input logic [1:0] nr_sel);
        case (nr_sel)
            2'd1:    return NR_192;
            2'd2:    return NR_256;
            default: return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Round controller for the multicycle AES datapath: runtime Nr, enc/dec direction,
// valid/ready on both sides with backpressure and synchronous abort.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int MAX_ROUNDS = 14,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_decrypt,
    input  logic [1:0]       nr_sel,
    output logic             load_state,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic             first_round,
    output logic             last_round,
    output logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    generate
        if (MAX_ROUNDS < NR_128 || (2 ** IDX_W) <= MAX_ROUNDS) begin : g_bad_param
            $error("aes_round_sequencer: MAX_ROUNDS/IDX_W out of range");
        end
    endgenerate

    seq_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0] r_nr, w_nr_nxt;
    logic             r_dir, w_dir_nxt;
    logic             w_in_ready;
    logic             w_load;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nr_nxt    = r_nr;
        w_dir_nxt   = r_dir;
        w_in_ready  = 1'b0;

        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            DONE:    w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
        if (rst || abort)
            w_in_ready = 1'b0;
        w_load = in_valid & w_in_ready;

        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = ROUND;
                    w_cnt_nxt   = IDX_W'(1);
                    w_dir_nxt   = in_decrypt;
                    w_nr_nxt    = IDX_W'(nr_decode(nr_sel));
                end
            end
            ROUND: begin
                if (r_cnt == r_nr) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + IDX_W'(1);
                end
            end
            DONE: begin
                // Handoff and next accept share a cycle so there is no bubble.
                if (out_ready) begin
                    if (w_load) begin
                        w_state_nxt = ROUND;
                        w_cnt_nxt   = IDX_W'(1);
                        w_dir_nxt   = in_decrypt;
                        w_nr_nxt    = IDX_W'(nr_decode(nr_sel));
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (abort) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_nr    <= IDX_W'(NR_128);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_nr    <= w_nr_nxt;
        end
    end

    // Decrypt walks the key schedule backwards: Nr-1 down to 0.
    assign round_en    = (r_state == ROUND);
    assign round_idx   = round_en ? (r_dir ? (r_nr - r_cnt) : r_cnt) : '0;
    assign first_round = round_en && (r_cnt == IDX_W'(1));
    assign last_round  = round_en && (r_cnt == r_nr);
    assign in_ready    = w_in_ready;
    assign load_state  = w_load;
    assign dir         = r_dir;
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench: stimulus pushes expected round/result records, a monitor pops and compares.
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_decrypt = 1'b0;
    logic [1:0] nr_sel = 2'd0;
    logic       out_ready = 1'b1;
    logic       in_ready, load_state, round_en, first_round, last_round, dir, out_valid, busy;
    logic [3:0] round_idx;

    aes_round_sequencer #(.MAX_ROUNDS(14), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt), .nr_sel(nr_sel),
        .load_state(load_state), .round_en(round_en), .round_idx(round_idx),
        .first_round(first_round), .last_round(last_round), .dir(dir),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] idx; logic first; logic last; logic d; } rexp_t;
    typedef struct { logic d; int at; } oexp_t;
    rexp_t rq[$];
    oexp_t oq[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Stimulus runs 1ns after negedge; monitor samples 3ns after negedge.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic dec, input logic [1:0] sel, input int nr);
        rexp_t r;
        oexp_t o;
        in_valid = 1'b1; in_decrypt = dec; nr_sel = sel;
        #1;
        chk("load_state_on_accept", load_state, 1);
        for (int c = 1; c <= nr; c++) begin
            r.idx   = dec ? 4'(nr - c) : 4'(c);
            r.first = (c == 1);
            r.last  = (c == nr);
            r.d     = dec;
            rq.push_back(r);
        end
        o.d = dec;
        o.at = cyc + 1 + nr;
        oq.push_back(o);
    endtask

    task automatic wait_ov(input int max, input string nm);
        for (int i = 0; i < max; i++) begin
            nxt();
            if (out_valid) return;
        end
        chk({nm, "_timeout"}, out_valid, 1);
    endtask

    initial begin : monitor
        logic  seen;
        rexp_t r;
        oexp_t o;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (round_en === 1'b1) begin
                if (rq.size() == 0) chk("round_en_unexpected", round_en, 0);
                else begin
                    r = rq.pop_front();
                    chk("round_idx", round_idx, r.idx);
                    chk("first_round", first_round, r.first);
                    chk("last_round", last_round, r.last);
                    chk("dir", dir, r.d);
                end
            end
            if (out_valid === 1'b1 && !seen) begin
                if (oq.size() == 0) chk("out_valid_unexpected", out_valid, 0);
                else begin
                    o = oq.pop_front();
                    chk("out_dir", dir, o.d);
                    chk("out_valid_cycle", cyc, o.at);
                end
                seen = 1'b1;
            end
            if (out_valid !== 1'b1 || out_ready) seen = 1'b0;
        end
    end

    initial begin : stim
        // reset behaviour
        nxt();
        in_valid = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_load_state", load_state, 0);
        nxt();
        in_valid = 1'b0;
        rst = 1'b0;
        nxt();
        chk("reset_round_idx", round_idx, 0);
        chk("reset_round_en", round_en, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_dir", dir, 0);
        chk("idle_in_ready", in_ready, 1);

        // 1: encrypt, Nr=10
        issue(1'b0, 2'd0, 10);
        nxt(); in_valid = 1'b0;
        wait_ov(20, "enc10");
        nxt();
        chk("enc10_idle_after", busy, 0);

        // 2+3: decrypt Nr=14 with 5 cycles of backpressure
        out_ready = 1'b0;
        issue(1'b1, 2'd2, 14);
        nxt(); in_valid = 1'b0;
        wait_ov(24, "dec14");
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_load_state", load_state, 0);
            chk("hold_round_en", round_en, 0);
            nxt();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        nxt();
        chk("release_to_idle", busy, 0);
        chk("release_out_valid", out_valid, 0);

        // 4: back-to-back handoff, Nr=12 enc then Nr=10 dec
        issue(1'b0, 2'd1, 12);
        nxt(); in_valid = 1'b0;
        wait_ov(22, "enc12");
        chk("b2b_in_ready", in_ready, 1);
        issue(1'b1, 2'd0, 10);
        nxt(); in_valid = 1'b0;
        chk("b2b_no_gap_round_en", round_en, 1);
        chk("b2b_out_valid_dropped", out_valid, 0);
        wait_ov(20, "dec10");
        nxt();

        // 5: abort at cnt=4
        issue(1'b0, 2'd0, 10);
        nxt(); in_valid = 1'b0;
        nxt(); nxt(); nxt();
        chk("abort_pre_idx", round_idx, 4);
        abort = 1'b1; in_valid = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_load_state", load_state, 0);
        nxt();
        abort = 1'b0; in_valid = 1'b0;
        rq.delete(); oq.delete();
        chk("abort_idle", busy, 0);
        chk("abort_round_en", round_en, 0);
        chk("abort_out_valid", out_valid, 0);
        repeat (12) nxt();
        issue(1'b0, 2'd0, 10);
        nxt(); in_valid = 1'b0;
        wait_ov(20, "post_abort");
        nxt();

        // 6: nr_sel=3 runs 10 rounds; then reset mid-block at cnt=7
        issue(1'b0, 2'd3, 10);
        nxt(); in_valid = 1'b0;
        wait_ov(20, "sel3");
        nxt();
        issue(1'b1, 2'd3, 10);
        nxt(); in_valid = 1'b0;
        repeat (6) nxt();
        chk("rst_pre_idx", round_idx, 3);
        rst = 1'b1; in_valid = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_load_state", load_state, 0);
        nxt();
        rq.delete(); oq.delete();
        chk("midrst_round_en", round_en, 0);
        chk("midrst_round_idx", round_idx, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_in_ready_hold", in_ready, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        repeat (3) nxt();
        chk("rq_drained", rq.size(), 0);
        chk("oq_drained", oq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
